w4_tile_reader: RTL

Read sequencer and int4 unpacker sitting directly downstream of the weight `buffer` in the W4A8 GEMM datapath.
- On `start` it walks a contiguous address range of the buffer and drives its `rd_en`/`rd_addr`.
- It captures the 1-cycle-latency `data_out`/`valid_out` return into a credit-controlled skid FIFO.
- It sign-extends every 4-bit weight nibble to int8 and presents the lanes on a valid/ready stream to the PE array.
- It sustains one word per cycle under no backpressure and never drops a returned word.

---
 rtl/w4a8_pkg.sv | 52 +++++
 rtl/skid_fifo.sv | 48 ++++
 rtl/w4_tile_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/w4a8_pkg.sv
// Shared types and int4 -> int8 unpack helpers for the W4A8 weight path.
// Define W4_ZERO_POINT_EN to make nibbles unsigned with a zero-point offset.
package w4a8_pkg;

  localparam int LANE_W    = 8;
  localparam int NIB_W     = 4;
  // Widest word the unpack helper supports (256-bit buffer word).
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_RUN   = 2'd1,
    RDR_DRAIN = 2'd2,
    RDR_DONE  = 2'd3
  } rdr_state_e;

`ifdef W4_ZERO_POINT_EN
  // Lane i = unsigned nibble i minus zp; result fits int8 as -15..15.
  function automatic logic [MAX_LANES*LANE_W-1:0] unpack_w4(
    input logic [MAX_LANES*NIB_W-1:0] word,
    input int                         n_lanes,
    input logic [NIB_W-1:0]           zp
  );
    logic [MAX_LANES*LANE_W-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n_lanes) begin
        lanes[i*LANE_W +: LANE_W] = {{(LANE_W-NIB_W){1'b0}}, word[i*NIB_W +: NIB_W]}
                                  - {{(LANE_W-NIB_W){1'b0}}, zp};
      end
    end
    return lanes;
  endfunction
`else
  // Lane i = two's-complement nibble i sign-extended to int8.
  function automatic logic [MAX_LANES*LANE_W-1:0] unpack_w4(
    input logic [MAX_LANES*NIB_W-1:0] word,
    input int                         n_lanes
  );
    logic [MAX_LANES*LANE_W-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n_lanes) begin
        lanes[i*LANE_W +: LANE_W] = {{(LANE_W-NIB_W){word[i*NIB_W+NIB_W-1]}},
                                     word[i*NIB_W +: NIB_W]};
      end
    end
    return lanes;
  endfunction
`endif

endpackage

// File: rtl/skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; absorbs the
// buffer's read return while the downstream stream is stalled.
module skid_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset too so the unpacked head reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_data;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // The credit loop upstream guarantees space for every returned word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/w4_tile_reader.sv
// Walks a buffer address range, captures the read return into a skid FIFO and
// streams sign-extended int8 lanes. W4_ZERO_POINT_EN adds the zp input.
module w4_tile_reader
  import w4a8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH:0]              num_words,
`ifdef W4_ZERO_POINT_EN
  input  logic [NIB_W-1:0]                 zp,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  input  logic                             rd_valid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANE_W*(DATA_WIDTH/NIB_W)-1:0] out_data,
  output logic                             out_last
);

  localparam int LANES  = DATA_WIDTH / NIB_W;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

  rdr_state_e            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [CNT_W-1:0]      num_q;
  logic [CNT_W-1:0]      remaining_q;
  logic [CNT_W-1:0]      popped_q;
  // Words issued but not yet handed downstream; bounds FIFO occupancy.
  logic [CRED_W-1:0]     credits_q;
  // Masks a stale read return in the first cycle after reset release.
  logic                  rst_guard_q;
`ifdef W4_ZERO_POINT_EN
  logic [NIB_W-1:0]      zp_q;
`endif

  logic                  out_hs;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign busy    = (state == RDR_RUN) || (state == RDR_DRAIN);
  assign done    = (state == RDR_DONE);
  assign rd_en   = (state == RDR_RUN) && (remaining_q != '0) && (credits_q < CRED_MAX);
  assign rd_addr = base_q + issued_q;

  assign out_valid = !fifo_empty;
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && (popped_q == num_q - CNT_W'(1));
  assign fifo_push = rd_valid && !rst_guard_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RDR_IDLE;
      base_q      <= '0;
      issued_q    <= '0;
      num_q       <= '0;
      remaining_q <= '0;
      popped_q    <= '0;
      credits_q   <= '0;
      rst_guard_q <= 1'b1;
`ifdef W4_ZERO_POINT_EN
      zp_q        <= '0;
`endif
    end else begin
      rst_guard_q <= 1'b0;

      if (rd_en) begin
        issued_q    <= issued_q + ADDR_WIDTH'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
      if (out_hs) popped_q <= popped_q + CNT_W'(1);

      case ({rd_en, out_hs})
        2'b10:   credits_q <= credits_q + CRED_W'(1);
        2'b01:   credits_q <= credits_q - CRED_W'(1);
        default: credits_q <= credits_q;
      endcase

      case (state)
        RDR_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            num_q       <= num_words;
            remaining_q <= num_words;
            issued_q    <= '0;
            popped_q    <= '0;
`ifdef W4_ZERO_POINT_EN
            zp_q        <= zp;
`endif
            state       <= (num_words == '0) ? RDR_DONE : RDR_RUN;
          end
        end
        RDR_RUN: begin
          if (rd_en && (remaining_q == CNT_W'(1))) state <= RDR_DRAIN;
        end
        RDR_DRAIN: begin
          if (out_hs && out_last) state <= RDR_DONE;
        end
        RDR_DONE: state <= RDR_IDLE;
        default:  state <= RDR_IDLE;
      endcase
    end
  end

  skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_skid_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rd_data),
    .pop       (out_hs),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  // Unpack at the FIFO output so stored words stay at 4 bits per weight.
  logic [MAX_LANES*NIB_W-1:0]  head_wide;
  logic [MAX_LANES*LANE_W-1:0] lanes_wide;
  logic                        unused_lanes;

  always_comb begin
    // NOTE: default the whole vector first so no bit is left unassigned (no latch).
    head_wide                   = '0;
    head_wide[DATA_WIDTH-1:0]   = fifo_head;
  end

`ifdef W4_ZERO_POINT_EN
  assign lanes_wide = unpack_w4(head_wide, LANES, zp_q);
`else
  assign lanes_wide = unpack_w4(head_wide, LANES);
`endif

  assign out_data     = lanes_wide[LANE_W*LANES-1:0];
  assign unused_lanes = ^lanes_wide;

endmodule
